// File: rtl/mcore_pkg.sv
// Shared constants and types for the mcore memory arbiter and its helpers.
package mcore_pkg;

    // Arbitration policy selectors for the PRIO_MODE parameter.
    localparam int MEM_ARB_RR    = 0;
    localparam int MEM_ARB_FIXED = 1;

    // Default client count of the mcore cel engine (fetch, pixel write, PIP, CLUT).
    localparam int MCORE_NUM_CH = 4;
    localparam int MCORE_CH_W   = $clog2(MCORE_NUM_CH);

    // Channel identifier as stored in the outstanding-transaction FIFO.
    typedef logic [MCORE_CH_W-1:0] ch_id_t;

endpackage : mcore_pkg

// File: rtl/mcore_id_fifo.sv
// Register-based FIFO of channel IDs for granted-but-unanswered memory
// transactions. The head entry is visible combinationally so a response can be
// routed in the same cycle it arrives.
module mcore_id_fifo
    import mcore_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = entry_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        entry_d  = entry_q;
        if (push) begin
            entry_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers and occupancy, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking <= so all flops update together at the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array: written only on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an entry is only read after it was written, gated by count.
        entry_q <= entry_d;
    end

endmodule : mcore_id_fifo

// File: rtl/mcore_mem_arbiter.sv
// N-channel arbiter merging cel-engine memory clients onto one mem_if master.
// Grants are zero-latency; each grant's channel is queued so in-order
// responses are steered back to the channel that issued them.
module mcore_mem_arbiter
    import mcore_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_CH          = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PRIO_MODE       = MEM_ARB_RR,
    localparam int CH_W  = $clog2(NUM_CH),
    localparam int BE_W  = DATA_WIDTH / 8,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    input  logic [NUM_CH*BE_W-1:0]       ch_be,
    output logic [NUM_CH-1:0]            ch_gnt,
    output logic [NUM_CH-1:0]            ch_rsp_valid,
    output logic [DATA_WIDTH-1:0]        ch_rsp_rdata,
    output logic                         ch_rsp_error,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_we,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [BE_W-1:0]              mem_be,
    input  logic                         mem_gnt,
    input  logic                         mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]        mem_rsp_rdata,
    input  logic                         mem_rsp_error,
    output logic [CNT_W-1:0]             outstanding_cnt,
    output logic                         err_unexp_rsp
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CH_W-1:0] locked_ch_q, locked_ch_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            err_q, err_d;

    logic [CH_W-1:0] winner;
    logic [CH_W-1:0] sel;
    logic            issue;
    logic            grant;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic [CH_W-1:0] fifo_head;

    // Winner search: lowest index for fixed priority, first requester at or after rr_ptr otherwise.
    always_comb begin
        winner = '0;
        if (PRIO_MODE == MEM_ARB_FIXED) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (ch_req[CH_W'(i)]) winner = CH_W'(i);
            end
        end else begin
            for (int off = NUM_CH - 1; off >= 0; off--) begin
                int pos;
                pos = int'(rr_ptr_q) + off;
                if (pos >= NUM_CH) pos = pos - NUM_CH;
                if (ch_req[CH_W'(pos)]) winner = CH_W'(pos);
            end
        end
    end

    // Issue decision and downstream request mux; outputs forced to zero while in reset.
    always_comb begin
        issue     = 1'b0;
        sel       = winner;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_be    = '0;
        if (state_q == ST_HOLD) begin
            // A stalled request stays on the bus even if the client lets go.
            issue = 1'b1;
            sel   = locked_ch_q;
        end else begin
            issue = (|ch_req) && !fifo_full;
        end
        if (issue && !areset) begin
            mem_req   = 1'b1;
            mem_addr  = ch_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_we    = ch_we[sel];
            mem_wdata = ch_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            mem_be    = ch_be[int'(sel)*BE_W +: BE_W];
        end
    end

    assign grant    = mem_req && mem_gnt;
    assign fifo_pop = mem_rsp_valid && !fifo_empty && !areset;

    // Grant and response steering back to the clients.
    always_comb begin
        ch_gnt       = '0;
        ch_rsp_valid = '0;
        ch_rsp_rdata = '0;
        ch_rsp_error = 1'b0;
        if (grant) ch_gnt[sel] = 1'b1;
        if (fifo_pop) begin
            ch_rsp_valid[fifo_head] = 1'b1;
            ch_rsp_rdata            = mem_rsp_rdata;
            ch_rsp_error            = mem_rsp_error;
        end
    end

    // FSM, round-robin pointer and sticky unexpected-response flag next-state.
    always_comb begin
        state_d     = state_q;
        locked_ch_d = locked_ch_q;
        rr_ptr_d    = rr_ptr_q;
        err_d       = err_q | (mem_rsp_valid && fifo_empty);
        if (state_q == ST_ARB) begin
            if (mem_req && !mem_gnt) begin
                state_d     = ST_HOLD;
                locked_ch_d = sel;
            end
        end else if (mem_gnt) begin
            state_d = ST_ARB;
        end
        if (grant && PRIO_MODE == MEM_ARB_RR) begin
            rr_ptr_d = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
        end
    end

    // Arbiter state registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_ARB;
            locked_ch_q <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_ch_q <= locked_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
        end
    end

    assign err_unexp_rsp = err_q;

    mcore_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (CH_W)
    ) u_id_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (grant),
        .push_data (sel),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding_cnt)
    );

endmodule : mcore_mem_arbiter

// File: tb/tb_mcore_mem_arbiter.sv
// Directed bench for mcore_mem_arbiter with default parameters (4 channels,
// round-robin, 4 outstanding). Inputs change 1ns after the rising edge and
// outputs are sampled 5ns after it, mid-cycle.
module tb_mcore_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NC = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic [NC-1:0] ch_req;
    logic [NC*AW-1:0] ch_addr;
    logic [NC-1:0] ch_we;
    logic [NC*DW-1:0] ch_wdata;
    logic [NC*4-1:0]  ch_be;
    logic [NC-1:0] ch_gnt;
    logic [NC-1:0] ch_rsp_valid;
    logic [DW-1:0] ch_rsp_rdata;
    logic          ch_rsp_error;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_gnt;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_rdata;
    logic          mem_rsp_error;
    logic [2:0]    outstanding_cnt;
    logic          err_unexp_rsp;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    mcore_mem_arbiter dut (
        .aclk            (aclk),
        .areset          (areset),
        .ch_req          (ch_req),
        .ch_addr         (ch_addr),
        .ch_we           (ch_we),
        .ch_wdata        (ch_wdata),
        .ch_be           (ch_be),
        .ch_gnt          (ch_gnt),
        .ch_rsp_valid    (ch_rsp_valid),
        .ch_rsp_rdata    (ch_rsp_rdata),
        .ch_rsp_error    (ch_rsp_error),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_gnt         (mem_gnt),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_rdata   (mem_rsp_rdata),
        .mem_rsp_error   (mem_rsp_error),
        .outstanding_cnt (outstanding_cnt),
        .err_unexp_rsp   (err_unexp_rsp)
    );

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    // Advance to 1ns after the next rising edge.
    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        ch_req = 4'b1111;
        #3;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
        total++; if (ch_gnt !== 4'b0000) begin bad++; $display("FAIL reset_ch_gnt got=%b exp=0000", ch_gnt); end
        total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", outstanding_cnt); end
        total++; if (err_unexp_rsp !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", err_unexp_rsp); end
        next_cycle();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_held_mem_req got=%0h exp=0", mem_req); end
        areset = 1'b0;
        ch_req = 4'b0000;
        next_cycle();
    endtask

    task automatic test_rr_fairness();
        for (int k = 0; k < 8; k++) begin
            ch_req        = 4'b1111;
            mem_gnt       = 1'b1;
            mem_rsp_valid = (k >= 1);
            #4;
            total++; if (ch_gnt !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, ch_gnt, 4'(1 << (k % 4))); end
            total++; if (ch_rsp_valid !== ((k >= 1) ? 4'(1 << ((k - 1) % 4)) : 4'b0000)) begin
                bad++; $display("FAIL rr_rsp[%0d] got=%b", k, ch_rsp_valid); end
            next_cycle();
        end
        ch_req = 4'b0000;
        mem_gnt = 1'b0;
        #4;
        total++; if (ch_rsp_valid !== 4'b1000) begin bad++; $display("FAIL rr_drain got=%b exp=1000", ch_rsp_valid); end
        next_cycle();
        mem_rsp_valid = 1'b0;
        #4;
        total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL rr_cnt got=%0d exp=0", outstanding_cnt); end
        next_cycle();
    endtask

    task automatic test_hold();
        for (int k = 0; k < 5; k++) begin
            ch_req  = (k == 0) ? 4'b0100 : (k < 4) ? 4'b0101 : 4'b0001;
            mem_gnt = (k >= 3);
            #4;
            if (k < 4) begin
                total++; if (mem_addr !== addr_of(2) || mem_req !== 1'b1) begin
                    bad++; $display("FAIL hold_addr[%0d] got=%h req=%0h exp=%h", k, mem_addr, mem_req, addr_of(2)); end
            end
            total++; if (ch_gnt !== ((k == 3) ? 4'b0100 : (k == 4) ? 4'b0001 : 4'b0000)) begin
                bad++; $display("FAIL hold_gnt[%0d] got=%b", k, ch_gnt); end
            next_cycle();
        end
        ch_req = 4'b0000;
        mem_gnt = 1'b0;
        mem_rsp_valid = 1'b1;
        #4;
        total++; if (ch_rsp_valid !== 4'b0100) begin bad++; $display("FAIL hold_rsp0 got=%b exp=0100", ch_rsp_valid); end
        next_cycle();
        #4;
        total++; if (ch_rsp_valid !== 4'b0001) begin bad++; $display("FAIL hold_rsp1 got=%b exp=0001", ch_rsp_valid); end
        next_cycle();
        mem_rsp_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_routing();
        logic [3:0]  exp_rsp [5];
        logic [31:0] exp_dat [5];
        logic [2:0]  exp_cnt [5];
        exp_rsp = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0010};
        exp_dat = '{32'h0, 32'h0, 32'hA, 32'hB, 32'hC};
        exp_cnt = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd1};
        for (int k = 0; k < 5; k++) begin
            ch_req        = (k == 1) ? 4'b1000 : (k == 0 || k == 2) ? 4'b0010 : 4'b0000;
            mem_gnt       = (k < 3);
            mem_rsp_valid = (k >= 2);
            mem_rsp_rdata = exp_dat[k];
            mem_rsp_error = (k == 3);
            #4;
            if (k < 3) begin
                total++; if (ch_gnt !== ch_req || mem_we !== 1'b0) begin
                    bad++; $display("FAIL route_gnt[%0d] got=%b we=%0h exp=%b", k, ch_gnt, mem_we, ch_req); end
            end
            total++; if (ch_rsp_valid !== exp_rsp[k]) begin bad++; $display("FAIL route_rsp[%0d] got=%b exp=%b", k, ch_rsp_valid, exp_rsp[k]); end
            if (k >= 2) begin
                total++; if (ch_rsp_rdata !== exp_dat[k] || ch_rsp_error !== (k == 3)) begin
                    bad++; $display("FAIL route_data[%0d] got=%h err=%0h exp=%h", k, ch_rsp_rdata, ch_rsp_error, exp_dat[k]); end
            end
            total++; if (outstanding_cnt !== exp_cnt[k]) begin bad++; $display("FAIL route_cnt[%0d] got=%0d exp=%0d", k, outstanding_cnt, exp_cnt[k]); end
            next_cycle();
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_error = 1'b0;
        #4;
        total++; if (outstanding_cnt !== 3'd0) begin bad++; $display("FAIL route_end_cnt got=%0d exp=0", outstanding_cnt); end
        next_cycle();
    endtask

    task automatic test_full();
        ch_we = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            ch_req        = (k < 7) ? 4'b0001 : 4'b0000;
            mem_gnt       = 1'b1;
            mem_rsp_valid = (k == 5);
            #4;
            if (k < 4 || k == 6) begin
                total++; if (ch_gnt !== 4'b0001 || mem_we !== 1'b1 || mem_wdata !== 32'hD0D0_0000 || mem_be !== 4'b0101) begin
                    bad++; $display("FAIL full_issue[%0d] gnt=%b we=%0h wd=%h be=%b", k, ch_gnt, mem_we, mem_wdata, mem_be); end
            end else if (k < 6) begin
                total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_block[%0d] got=%0h exp=0", k, mem_req); end
            end
            total++; if (outstanding_cnt !== ((k < 4) ? 3'(k) : (k == 6) ? 3'd3 : 3'd4)) begin
                bad++; $display("FAIL full_cnt[%0d] got=%0d", k, outstanding_cnt); end
            if (k == 5) begin
                total++; if (ch_rsp_valid !== 4'b0001) begin bad++; $display("FAIL full_rsp got=%b exp=0001", ch_rsp_valid); end
            end
            next_cycle();
        end
        ch_we = 4'b0000;
        mem_gnt = 1'b0;
        mem_rsp_valid = 1'b1;
        repeat (4) next_cycle();
        mem_rsp_valid = 1'b0;
        #4;
        total++; if (outstanding_cnt !== 3'd0 || err_unexp_rsp !== 1'b0) begin
            bad++; $display("FAIL full_drain cnt=%0d err=%0h exp=0/0", outstanding_cnt, err_unexp_rsp); end
        next_cycle();
    endtask

    task automatic test_unexpected_rsp();
        mem_rsp_valid = 1'b1;
        #4;
        total++; if (ch_rsp_valid !== 4'b0000) begin bad++; $display("FAIL unexp_rsp got=%b exp=0000", ch_rsp_valid); end
        next_cycle();
        mem_rsp_valid = 1'b0;
        #4;
        total++; if (err_unexp_rsp !== 1'b1) begin bad++; $display("FAIL unexp_set got=%0h exp=1", err_unexp_rsp); end
        repeat (3) next_cycle();
        total++; if (err_unexp_rsp !== 1'b1) begin bad++; $display("FAIL unexp_sticky got=%0h exp=1", err_unexp_rsp); end
    endtask

    task automatic test_reset_midflight();
        ch_req  = 4'b0010;
        mem_gnt = 1'b1;
        next_cycle();
        ch_req  = 4'b0000;
        mem_gnt = 1'b0;
        #4;
        total++; if (outstanding_cnt !== 3'd1) begin bad++; $display("FAIL mid_cnt got=%0d exp=1", outstanding_cnt); end
        ch_req = 4'b1111;
        areset = 1'b1;
        #1;
        total++; if (outstanding_cnt !== 3'd0 || err_unexp_rsp !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL mid_reset cnt=%0d err=%0h req=%0h exp=0/0/0", outstanding_cnt, err_unexp_rsp, mem_req); end
        next_cycle();
        areset = 1'b0;
        ch_req = 4'b0000;
        mem_rsp_valid = 1'b1;
        #4;
        total++; if (ch_rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_late_rsp got=%b exp=0000", ch_rsp_valid); end
        next_cycle();
        mem_rsp_valid = 1'b0;
        #4;
        total++; if (err_unexp_rsp !== 1'b1) begin bad++; $display("FAIL mid_late_err got=%0h exp=1", err_unexp_rsp); end
    endtask

    initial begin
        ch_req = '0;
        ch_we  = '0;
        for (int i = 0; i < NC; i++) begin
            ch_addr[i*AW +: AW]  = addr_of(i);
            ch_wdata[i*DW +: DW] = 32'hD0D0_0000 + 32'(i);
            ch_be[i*4 +: 4]      = (i == 0) ? 4'b0101 : 4'b1111;
        end
        mem_gnt       = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        mem_rsp_error = 1'b0;

        test_reset();
        test_rr_fairness();
        test_hold();
        test_routing();
        test_full();
        test_unexpected_rsp();
        test_reset_midflight();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mcore_mem_arbiter
